// File: rtl/example_reduce_pipe.sv
// Multi-channel bitwise reducer (OR/AND/XOR/sticky-OR accumulate) with a 2-entry valid/ready output buffer.
// Optional macro EXAMPLE_REDUCE_PARITY_EN adds out_parity, stored per buffer entry at push time.
module example_reduce_pipe #(
  parameter int WIDTH  = 1,
  parameter int NUM_CH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [1:0]              in_mode,
  input  logic                    acc_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data
`ifdef EXAMPLE_REDUCE_PARITY_EN
  ,
  output logic                    out_parity
`endif
);

  localparam logic [1:0] MODE_OR  = 2'd0;
  localparam logic [1:0] MODE_AND = 2'd1;
  localparam logic [1:0] MODE_XOR = 2'd2;
  localparam logic [1:0] MODE_ACC = 2'd3;

  logic [1:0]       count;
  logic [WIDTH-1:0] tail_data;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] red_or;
  logic [WIDTH-1:0] red_and;
  logic [WIDTH-1:0] red_xor;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] push_data;
  logic             push;
  logic             pop;

  // Ready depends only on the registered occupancy, never on out_ready.
  assign in_ready  = ~rst & (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    red_or  = '0;
    red_and = '1;
    red_xor = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      red_or  = red_or  | in_data[c*WIDTH +: WIDTH];
      red_and = red_and & in_data[c*WIDTH +: WIDTH];
      red_xor = red_xor ^ in_data[c*WIDTH +: WIDTH];
    end
  end

  assign acc_next = (acc_clr ? '0 : acc) | red_or;

  always_comb begin
    push_data = red_or;
    case (in_mode)
      MODE_OR:  push_data = red_or;
      MODE_AND: push_data = red_and;
      MODE_XOR: push_data = red_xor;
      MODE_ACC: push_data = acc_next;
      default:  push_data = red_or;
    endcase
  end

  // A bare acc_clr (or one alongside a non-accumulate transfer) still empties the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (push && (in_mode == MODE_ACC)) begin
      acc <= acc_next;
    end else if (acc_clr) begin
      acc <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // out_data is the head register itself, so it keeps its last value once the buffer drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      tail_data <= '0;
    end else begin
      if (pop && (count == 2'd2)) begin
        out_data <= tail_data;
      end
      if (push) begin
        if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
          out_data <= push_data;
        end else begin
          tail_data <= push_data;
        end
      end
    end
  end

`ifdef EXAMPLE_REDUCE_PARITY_EN
  logic tail_parity;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_parity  <= 1'b0;
      tail_parity <= 1'b0;
    end else begin
      if (pop && (count == 2'd2)) begin
        out_parity <= tail_parity;
      end
      if (push) begin
        if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
          out_parity <= ^push_data;
        end else begin
          tail_parity <= ^push_data;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_example_reduce_pipe.sv
// Randomized and directed bench for example_reduce_pipe (WIDTH=4, NUM_CH=3) against a queue-based model.
// Define EXAMPLE_REDUCE_PARITY_EN to also check out_parity.
module tb_example_reduce_pipe;

  localparam int WIDTH  = 4;
  localparam int NUM_CH = 3;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [1:0]              in_mode;
  logic                    acc_clr;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
`ifdef EXAMPLE_REDUCE_PARITY_EN
  logic                    out_parity;
`endif

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_acc;
  logic [WIDTH-1:0] m_out;

  example_reduce_pipe #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_mode(in_mode),
    .acc_clr(acc_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
`ifdef EXAMPLE_REDUCE_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reduction written from the per-bit rules: each result bit looks at that bit of every channel.
  function automatic logic [WIDTH-1:0] refReduce(input logic [NUM_CH*WIDTH-1:0] d, input logic [1:0] m);
    logic [WIDTH-1:0] r;
    int ones;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = 0;
      for (int c = 0; c < NUM_CH; c++) ones += int'(d[c*WIDTH + i]);
      case (m)
        2'd1:    r[i] = (ones == NUM_CH);
        2'd2:    r[i] = (ones % 2 == 1);
        default: r[i] = (ones > 0);
      endcase
    end
    return r;
  endfunction

  // One clock cycle: drive, check at the falling edge, then advance the model past the rising edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [NUM_CH*WIDTH-1:0] d,
                               input logic [1:0] m, input logic c, input logic o);
    logic             acc_now;
    logic             pop_now;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] dropped;
    rst       = r;
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    acc_clr   = c;
    out_ready = o;
    @(negedge clk);
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, (!r && exp_q.size() < 2)});
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, (exp_q.size() != 0)});
    checkOutput("out_data", {28'd0, out_data}, {28'd0, m_out});
`ifdef EXAMPLE_REDUCE_PARITY_EN
    checkOutput("out_parity", {31'd0, out_parity}, {31'd0, ^m_out});
`endif
    acc_now = v && !r && (exp_q.size() < 2);
    pop_now = !r && (exp_q.size() != 0) && o;
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      m_acc = '0;
      m_out = '0;
    end else begin
      res = refReduce(d, m);
      if (acc_now && m == 2'd3) begin
        m_acc = (c ? '0 : m_acc) | res;
        res   = m_acc;
      end else if (c) begin
        m_acc = '0;
      end
      if (pop_now) dropped = exp_q.pop_front();
      if (acc_now) exp_q.push_back(res);
      if (exp_q.size() != 0) m_out = exp_q[0];
    end
  endtask

  initial begin
    logic [NUM_CH*WIDTH-1:0] d147;
    d147 = {4'h4, 4'h2, 4'h1};
    m_acc = '0;
    m_out = '0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 2'd0; acc_clr = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1, 0, '0, 0, 0, 0);
    applyStimulus(1, 1, d147, 0, 0, 1);

    // OR / AND / XOR of channels 1, 2, 4
    applyStimulus(0, 1, d147, 0, 0, 1);
    checkOutput("or_result", {28'd0, out_data}, 32'h7);
    checkOutput("or_valid", {31'd0, out_valid}, 32'd1);
    applyStimulus(0, 1, d147, 1, 0, 1);
    checkOutput("and_result", {28'd0, out_data}, 32'h0);
    applyStimulus(0, 1, d147, 2, 0, 1);
    checkOutput("xor_result", {28'd0, out_data}, 32'h7);
    applyStimulus(0, 0, '0, 0, 0, 1);

    // Sticky-OR accumulate sequence
    applyStimulus(0, 1, {8'h0, 4'h1}, 3, 0, 1);
    checkOutput("acc_1", {28'd0, out_data}, 32'h1);
    applyStimulus(0, 1, {8'h0, 4'h8}, 3, 0, 1);
    checkOutput("acc_9", {28'd0, out_data}, 32'h9);
    applyStimulus(0, 1, {8'h0, 4'h2}, 3, 1, 1);
    checkOutput("acc_clr_2", {28'd0, out_data}, 32'h2);
    applyStimulus(0, 0, '0, 3, 1, 1);
    checkOutput("clr_no_push", {31'd0, out_valid}, 32'd0);
    applyStimulus(0, 1, {8'h0, 4'h0}, 3, 0, 1);
    checkOutput("acc_after_clr", {28'd0, out_data}, 32'h0);
    checkOutput("acc_after_clr_v", {31'd0, out_valid}, 32'd1);
    applyStimulus(0, 0, '0, 0, 0, 1);

    // Backpressure: two accepted, third waits until a slot frees
    applyStimulus(0, 1, {8'h0, 4'h1}, 0, 0, 0);
    applyStimulus(0, 1, {8'h0, 4'h2}, 0, 0, 0);
    checkOutput("bp_full_ready", {31'd0, in_ready}, 32'd0);
    applyStimulus(0, 1, {8'h0, 4'h3}, 0, 0, 0);
    applyStimulus(0, 1, {8'h0, 4'h3}, 0, 0, 1);
    checkOutput("bp_second_head", {28'd0, out_data}, 32'h2);
    applyStimulus(0, 1, {8'h0, 4'h3}, 0, 0, 1);
    checkOutput("bp_third_head", {28'd0, out_data}, 32'h3);
    applyStimulus(0, 0, '0, 0, 0, 1);

    // Steady push and pop with one entry resident
    applyStimulus(0, 1, {8'h0, 4'h0}, 0, 0, 1);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(0, 1, {8'h0, 4'(k)}, 0, 0, 1);
      checkOutput("pp_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("pp_data", {28'd0, out_data}, k);
    end
    applyStimulus(0, 0, '0, 0, 0, 1);

    // Reset while full with a saturated accumulator
    applyStimulus(0, 1, {8'h0, 4'hF}, 3, 0, 0);
    applyStimulus(0, 1, {8'h0, 4'hF}, 3, 0, 0);
    applyStimulus(1, 1, {8'h0, 4'hF}, 3, 0, 1);
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_data", {28'd0, out_data}, 32'h0);
    applyStimulus(0, 1, {8'h0, 4'h1}, 3, 0, 1);
    checkOutput("rst_acc", {28'd0, out_data}, 32'h1);

    // Results 7 then 9 for parity
    applyStimulus(0, 1, d147, 0, 0, 1);
`ifdef EXAMPLE_REDUCE_PARITY_EN
    checkOutput("parity_7", {31'd0, out_parity}, 32'd1);
`endif
    applyStimulus(0, 1, {8'h0, 4'h9}, 3, 1, 1);
    checkOutput("result_9", {28'd0, out_data}, 32'h9);
`ifdef EXAMPLE_REDUCE_PARITY_EN
    checkOutput("parity_9", {31'd0, out_parity}, 32'd0);
`endif

    for (int n = 0; n < 500; n++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 3) != 0),
                    12'($urandom),
                    2'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 2) != 0));
    end
    applyStimulus(0, 0, '0, 0, 0, 1);
    applyStimulus(0, 0, '0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
